// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: latches each instruction into an internal IR and walks it through
// FETCH/DECODE/EXEC/MEM/WB. Every select and write enable is driven from the current state.
module mc_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RET_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             br_cond,
  input  logic             dm_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             dm_req,
  output logic             dm_we,
  output logic [2:0]       dm_ctrl,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       alu_func3,
  output logic             alu_subsra,
  output logic             sel_next_pc,
  output logic             sel_op1,
  output logic             sel_op2,
  output logic [1:0]       sel_wb,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [RET_W-1:0] retired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t           state, next_state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cause_set;
  logic [1:0]       cause_next;
  logic             alu_en;
  logic             ex_op1, ex_op2, ex_ss;
  logic [2:0]       ex_f3;
  logic             unused_ir_bits;

  logic [6:0] opcode;
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_legal;

  assign opcode    = ir[6:0];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;

  assign rs1     = is_lui ? 5'd0 : ir[19:15];
  assign rs2     = ir[24:20];
  assign rd      = ir[11:7];
  assign dm_ctrl = ir[14:12];
  assign halted  = (state == HALT);
  assign unused_ir_bits = ^{ir[31], ir[29:25]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ir <= 32'd0;
    else if (ir_we) ir <= instr;
  end

  // Counter is cleared while in EXEC so it always starts at zero on MEM entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         tmo_cnt <= '0;
    else if (state == EXEC)             tmo_cnt <= '0;
    else if (state == MEM && !dm_ready) tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     retired <= '0;
    else if (pc_we) retired <= retired + RET_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         halt_cause <= 2'b00;
    else if (cause_set) halt_cause <= cause_next;
  end

  always_comb begin
    ex_op1 = 1'b1;
    ex_op2 = 1'b1;
    ex_f3  = 3'b000;
    ex_ss  = 1'b0;
    if (is_r) begin
      ex_op2 = 1'b0;
      ex_f3  = ir[14:12];
      ex_ss  = ir[30];
    end else if (is_i) begin
      ex_f3 = ir[14:12];
      ex_ss = (ir[14:12] == 3'b101) & ir[30];
    end else if (is_branch | is_jal | is_auipc) begin
      ex_op1 = 1'b0;
    end
  end

  always_comb begin
    next_state  = state;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    sel_next_pc = 1'b0;
    sel_wb      = 2'b00;
    sel_op1     = 1'b0;
    sel_op2     = 1'b0;
    alu_func3   = 3'b000;
    alu_subsra  = 1'b0;
    alu_en      = 1'b0;
    cause_set   = 1'b0;
    cause_next  = 2'b00;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH: begin
        ir_we      = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (is_legal) begin
          next_state = EXEC;
        end else begin
          next_state = HALT;
          cause_set  = 1'b1;
          cause_next = 2'b01;
        end
      end
      EXEC: begin
        alu_en = 1'b1;
        if (is_branch) begin
          pc_we       = 1'b1;
          sel_next_pc = br_cond;
          next_state  = FETCH;
        end else if (is_load | is_store) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      // dm_ready wins over the timeout when both land in the same cycle
      MEM: begin
        alu_en = 1'b1;
        dm_req = 1'b1;
        dm_we  = is_store;
        if (dm_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (tmo_cnt == CNT_LAST) begin
          next_state = HALT;
          cause_set  = 1'b1;
          cause_next = 2'b10;
        end
      end
      WB: begin
        alu_en      = 1'b1;
        rf_we       = 1'b1;
        pc_we       = 1'b1;
        sel_next_pc = is_jal | is_jalr;
        if (is_load)                sel_wb = 2'b00;
        else if (is_jal | is_jalr)  sel_wb = 2'b10;
        else                        sel_wb = 2'b01;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
    if (alu_en) begin
      sel_op1    = ex_op1;
      sel_op2    = ex_op2;
      alu_func3  = ex_f3;
      alu_subsra = ex_ss;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each scenario queues per-cycle stimulus with the
// expected control outputs, then drains the queue comparing against the DUT.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        br_cond, dm_ready;
  logic        ir_we, pc_we, rf_we, dm_req, dm_we;
  logic [2:0]  dm_ctrl;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  alu_func3;
  logic        alu_subsra, sel_next_pc, sel_op1, sel_op2;
  logic [1:0]  sel_wb;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic        br;
    logic        rdy;
    logic [19:0] exp;
    int          ret;
  } cyc_t;

  cyc_t sb[$];

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] ADDI2 = 32'h40008293;
  localparam logic [31:0] ADD   = 32'h00108133;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] SRAI  = 32'h4020D213;
  localparam logic [31:0] SW    = 32'h0020A223;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] LW    = 32'h0000A183;
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT_CYCLES(16), .RET_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .br_cond(br_cond), .dm_ready(dm_ready),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .dm_req(dm_req), .dm_we(dm_we),
    .dm_ctrl(dm_ctrl), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_func3(alu_func3),
    .alu_subsra(alu_subsra), .sel_next_pc(sel_next_pc), .sel_op1(sel_op1), .sel_op2(sel_op2),
    .sel_wb(sel_wb), .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  // en = {ir_we, pc_we, rf_we, dm_req, dm_we, sel_next_pc, sel_op1, sel_op2}
  function automatic logic [19:0] ex(input logic [7:0] en, input logic [1:0] wb,
                                     input logic [2:0] f3, input logic ss, input logic h,
                                     input logic [4:0] r);
    return {en, wb, f3, ss, h, r};
  endfunction

  function automatic logic [19:0] observed();
    return {ir_we, pc_we, rf_we, dm_req, dm_we, sel_next_pc, sel_op1, sel_op2,
            sel_wb, alu_func3, alu_subsra, halted, rd};
  endfunction

  function automatic void push(input string tag, input logic [31:0] ins, input logic br,
                               input logic rdy, input logic [19:0] exp, input int ret = -1);
    cyc_t c;
    c.tag = tag; c.ins = ins; c.br = br; c.rdy = rdy; c.exp = exp; c.ret = ret;
    sb.push_back(c);
  endfunction

  task automatic do_reset();
    sb.delete();
    @(negedge clk);
    reset = 1'b0; instr = 32'd0; br_cond = 1'b0; dm_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; instr = ADDI; br_cond = 1'b1; dm_ready = 1'b1;
    #1;
    checks++;
    if (observed() !== 20'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %05h want %05h", observed(), 20'h0);
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_retired: got %0d want 0", retired);
    end
    checks++;
    if (halt_cause !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_cause: got %b want 00", halt_cause);
    end
    checks++;
    if ({dm_ctrl, rs1, rs2} !== 13'h0) begin
      errors++; $display("[TB] FAIL reset_fields: got %04h want 0000", {dm_ctrl, rs1, rs2});
    end
  endtask

  task automatic test_alu_ops();
    cyc_t c;
    do_reset();
    push("alu_idle",   ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("addi_fetch", ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("addi_dec",   ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd1));
    push("addi_exec",  ADDI, 0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd1));
    push("addi_wb",    ADDI, 0, 0, ex(8'h63, 2'b01, 3'd0, 0, 0, 5'd1));
    push("add_fetch",  ADD,  0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd1), 1);
    push("add_dec",    ADD,  0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd2));
    push("add_exec",   ADD,  0, 0, ex(8'h02, 2'b00, 3'd0, 0, 0, 5'd2));
    push("add_wb",     ADD,  0, 0, ex(8'h62, 2'b01, 3'd0, 0, 0, 5'd2));
    push("sub_fetch",  SUB,  0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd2), 2);
    push("sub_dec",    SUB,  0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd3));
    push("sub_exec",   SUB,  0, 0, ex(8'h02, 2'b00, 3'd0, 1, 0, 5'd3));
    push("sub_wb",     SUB,  0, 0, ex(8'h62, 2'b01, 3'd0, 1, 0, 5'd3));
    push("srai_fetch", SRAI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd3), 3);
    push("srai_dec",   SRAI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd4));
    push("srai_exec",  SRAI, 0, 0, ex(8'h03, 2'b00, 3'd5, 1, 0, 5'd4));
    push("srai_wb",    SRAI, 0, 0, ex(8'h63, 2'b01, 3'd5, 1, 0, 5'd4));
    push("addi2_fetch",ADDI2,0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd4), 4);
    push("addi2_dec",  ADDI2,0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd5));
    push("addi2_exec", ADDI2,0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd5));
    push("addi2_wb",   ADDI2,0, 0, ex(8'h63, 2'b01, 3'd0, 0, 0, 5'd5));
    push("alu_next",   ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd5), 5);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  task automatic test_store_wait();
    cyc_t c;
    do_reset();
    push("sw_idle",  SW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("sw_fetch", SW, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("sw_dec",   SW, 0, 1, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd4));
    push("sw_exec",  SW, 0, 1, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd4));
    for (int i = 0; i < 3; i++)
      push($sformatf("sw_wait%0d", i), SW, 0, 0, ex(8'h1B, 2'b00, 3'd0, 0, 0, 5'd4), 0);
    push("sw_done",  SW, 0, 1, ex(8'h5B, 2'b00, 3'd0, 0, 0, 5'd4), 0);
    push("sw_next",  ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd4), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    do_reset();
    push("beq_idle",   BEQ, 1, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("beq_fetch",  BEQ, 1, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("beq_dec",    BEQ, 1, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd8));
    push("beq_taken",  BEQ, 1, 0, ex(8'h45, 2'b00, 3'd0, 0, 0, 5'd8));
    push("beq_fetch2", BEQ, 1, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd8), 1);
    push("beq_dec2",   BEQ, 1, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd8));
    push("beq_nottkn", BEQ, 0, 0, ex(8'h41, 2'b00, 3'd0, 0, 0, 5'd8));
    push("beq_next",   ADDI, 1, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd8), 2);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  task automatic test_jal();
    cyc_t c;
    do_reset();
    push("jal_idle",  JAL, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("jal_fetch", JAL, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("jal_dec",   JAL, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd1));
    push("jal_exec",  JAL, 0, 0, ex(8'h01, 2'b00, 3'd0, 0, 0, 5'd1));
    push("jal_wb",    JAL, 0, 0, ex(8'h65, 2'b10, 3'd0, 0, 0, 5'd1), 0);
    push("jal_next",  ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd1), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    do_reset();
    push("ill_idle",  ILL, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("ill_fetch", ILL, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("ill_dec",   ILL, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd31));
    for (int i = 0; i < 4; i++)
      push($sformatf("ill_halt%0d", i), ADDI, 1, 1, ex(8'h00, 2'b00, 3'd0, 0, 1, 5'd31), 0);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
    checks++;
    if (halt_cause !== 2'b01) begin
      errors++; $display("[TB] FAIL ill_cause: got %b want 01", halt_cause);
    end
  endtask

  task automatic test_timeout();
    cyc_t c;
    do_reset();
    push("tmo_idle",  LW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("tmo_fetch", LW, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("tmo_dec",   LW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd3));
    push("tmo_exec",  LW, 0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd3));
    for (int i = 0; i < 16; i++)
      push($sformatf("tmo_mem%0d", i), LW, 0, 0, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3));
    for (int i = 0; i < 2; i++)
      push($sformatf("tmo_halt%0d", i), LW, 0, 1, ex(8'h00, 2'b00, 3'd0, 0, 1, 5'd3), 0);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
    checks++;
    if (halt_cause !== 2'b10) begin
      errors++; $display("[TB] FAIL tmo_cause: got %b want 10", halt_cause);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    do_reset();
    push("lw_idle",  LW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("lw_fetch", LW, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("lw_dec",   LW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw_exec",  LW, 0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd3));
    for (int i = 0; i < 15; i++)
      push($sformatf("lw_wait%0d", i), LW, 0, 0, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw_ready_at_limit", LW, 0, 1, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3), 0);
    push("lw_wb",     LW, 0, 0, ex(8'h63, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw2_fetch", LW, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd3), 1);
    push("lw2_dec",   LW, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw2_exec",  LW, 0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw2_mem",   LW, 0, 1, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw2_wb",    LW, 0, 0, ex(8'h63, 2'b00, 3'd0, 0, 0, 5'd3));
    push("lw_next",   ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd3), 2);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    cyc_t c;
    do_reset();
    push("rml_idle",   ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0));
    push("rml_fetch",  ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0));
    push("rml_dec",    ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd1));
    push("rml_exec",   ADDI, 0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd1));
    push("rml_wb",     ADDI, 0, 0, ex(8'h63, 2'b01, 3'd0, 0, 0, 5'd1));
    push("rml_lw_f",   LW,   0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd1), 1);
    push("rml_lw_d",   LW,   0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd3));
    push("rml_lw_e",   LW,   0, 0, ex(8'h03, 2'b00, 3'd0, 0, 0, 5'd3));
    push("rml_mem0",   LW,   0, 0, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3));
    push("rml_mem1",   LW,   0, 0, ex(8'h13, 2'b00, 3'd0, 0, 0, 5'd3), 1);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
    @(posedge clk);
    #2 reset = 1'b0;
    dm_ready = 1'b1;
    #1;
    checks++;
    if (observed() !== 20'h0) begin
      errors++; $display("[TB] FAIL rml_in_reset: got %05h want %05h", observed(), 20'h0);
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("[TB] FAIL rml_retired_cleared: got %0d want 0", retired);
    end
    @(negedge clk); #1;
    checks++;
    if ({pc_we, rf_we, dm_req} !== 3'b000) begin
      errors++; $display("[TB] FAIL rml_held: got %b want 000", {pc_we, rf_we, dm_req});
    end
    @(posedge clk);
    #2 reset = 1'b1;
    push("rml_rel_idle",  ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd0), 0);
    push("rml_rel_fetch", ADDI, 0, 0, ex(8'h80, 2'b00, 3'd0, 0, 0, 5'd0), 0);
    push("rml_rel_dec",   ADDI, 0, 0, ex(8'h00, 2'b00, 3'd0, 0, 0, 5'd1));
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk); instr = c.ins; br_cond = c.br; dm_ready = c.rdy; #1;
      checks++;
      if (observed() !== c.exp) begin
        errors++; $display("[TB] FAIL %s: got %05h want %05h", c.tag, observed(), c.exp);
      end
      if (c.ret >= 0) begin
        checks++;
        if (retired !== 32'(c.ret)) begin
          errors++; $display("[TB] FAIL %s_retired: got %0d want %0d", c.tag, retired, c.ret);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; instr = 32'd0; br_cond = 1'b0; dm_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_store_wait();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
